// File: rtl/exec_writeback.sv
// exec_writeback: writeback stage after the 16-bit ALU. It registers results,
// keeps the SZCV flag register, resolves branches, latches OUT data behind a
// ready/valid handshake and holds the HLT state.
// Optional feature macro: EXEC_WB_FLAG_BYPASS_EN. When it is defined, branch
// conditions use the next-state flags and a flag_fwd_hit output is added.
module exec_writeback #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_is_branch,
  input  logic [3:0]    in_opcode,
  input  logic [2:0]    in_cond,
  input  logic [DW-1:0] in_result,
  input  logic [RW-1:0] in_rd,
  input  logic          in_v,
  input  logic          in_z,
  input  logic          in_c,
  input  logic          in_s,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [3:0]    flags,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          halted
`ifdef EXEC_WB_FLAG_BYPASS_EN
  ,
  output logic          flag_fwd_hit
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    OUT_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_IN  = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t     state;
  logic       accept_c;
  logic       op_wr_c;
  logic       op_fl_c;
  logic [3:0] cond_flags_c;
  logic       take_c;

  assign accept_c = in_valid && in_ready;

  // Decode which ALU opcodes write the register file and which update flags.
  always_comb begin
    op_wr_c = 1'b0;
    op_fl_c = 1'b0;
    case (in_opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
      4'd8, 4'd9, 4'd10, 4'd11: begin
        op_wr_c = 1'b1;
        op_fl_c = 1'b1;
      end
      OP_CMP:  op_fl_c = 1'b1;
      OP_IN:   op_wr_c = 1'b1;
      default: ;
    endcase
  end

`ifdef EXEC_WB_FLAG_BYPASS_EN
  logic [3:0] flags_nxt_c;

  // Next-state flags, so a flag write committing this edge is seen by the branch.
  always_comb begin
    flags_nxt_c = flags;
    if (accept_c && !in_is_branch && op_fl_c)
      flags_nxt_c = {in_s, in_z, in_c, in_v};
  end
  assign cond_flags_c = flags_nxt_c;
`else
  assign cond_flags_c = flags;
`endif

  // Branch condition evaluated on {S,Z,C,V}.
  always_comb begin
    take_c = 1'b0;
    case (in_cond)
      3'd0:    take_c = cond_flags_c[2];
      3'd1:    take_c = cond_flags_c[3] ^ cond_flags_c[0];
      3'd2:    take_c = cond_flags_c[2] | (cond_flags_c[3] ^ cond_flags_c[0]);
      3'd3:    take_c = ~cond_flags_c[2];
      3'd4:    take_c = 1'b1;
      default: take_c = 1'b0;
    endcase
  end

  // State machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      in_ready  <= 1'b1;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      flags     <= 4'd0;
      br_taken  <= 1'b0;
      br_target <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
`ifdef EXEC_WB_FLAG_BYPASS_EN
      flag_fwd_hit <= 1'b0;
`endif
    end else begin
      rf_we    <= 1'b0;
      br_taken <= 1'b0;
`ifdef EXEC_WB_FLAG_BYPASS_EN
      flag_fwd_hit <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (accept_c) begin
            if (in_is_branch) begin
              if (take_c) begin
                br_taken  <= 1'b1;
                br_target <= in_result;
              end
`ifdef EXEC_WB_FLAG_BYPASS_EN
              flag_fwd_hit <= (flags_nxt_c != flags);
`endif
            end else begin
              if (op_wr_c) begin
                rf_we    <= 1'b1;
                rf_waddr <= in_rd;
                rf_wdata <= in_result;
              end
              if (op_fl_c)
                flags <= {in_s, in_z, in_c, in_v};
              if (in_opcode == OP_OUT) begin
                out_data  <= in_result;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
                state     <= OUT_WAIT;
              end
              if (in_opcode == OP_HLT) begin
                halted   <= 1'b1;
                in_ready <= 1'b0;
                state    <= HALTED;
              end
            end
          end
        end
        OUT_WAIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= RUN;
          end
        end
        HALTED: ;
        default: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_writeback.sv
// Directed testbench for exec_writeback with hand-computed expected values.
module tb_exec_writeback;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_is_branch;
  logic [3:0]    in_opcode;
  logic [2:0]    in_cond;
  logic [DW-1:0] in_result;
  logic [RW-1:0] in_rd;
  logic          in_v, in_z, in_c, in_s;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    flags;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          halted;
`ifdef EXEC_WB_FLAG_BYPASS_EN
  logic          flag_fwd_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exec_writeback #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_branch(in_is_branch), .in_opcode(in_opcode), .in_cond(in_cond),
    .in_result(in_result), .in_rd(in_rd),
    .in_v(in_v), .in_z(in_z), .in_c(in_c), .in_s(in_s),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .br_taken(br_taken), .br_target(br_target),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
`ifdef EXEC_WB_FLAG_BYPASS_EN
    , .flag_fwd_hit(flag_fwd_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] res, input logic [2:0] rd,
                     input logic s, input logic z, input logic c, input logic v);
    in_valid = 1'b1; in_is_branch = 1'b0; in_opcode = op; in_cond = 3'd0;
    in_result = res; in_rd = rd; in_s = s; in_z = z; in_c = c; in_v = v;
  endtask

  task automatic br(input logic [2:0] cond, input logic [15:0] tgt);
    in_valid = 1'b1; in_is_branch = 1'b1; in_opcode = 4'd0; in_cond = cond;
    in_result = tgt; in_rd = 3'd7; in_s = 1'b1; in_z = 1'b1; in_c = 1'b1; in_v = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_is_branch = 1'b0; in_opcode = 4'd0; in_cond = 3'd0;
    in_result = '0; in_rd = '0; in_s = 1'b0; in_z = 1'b0; in_c = 1'b0; in_v = 1'b0;
  endtask

  // Set flags with a CMP, then present one branch and check the decision.
  task automatic cmp_br(input string tag, input logic s, input logic z, input logic v,
                        input logic [2:0] cond, input logic [15:0] tgt,
                        input logic exp_taken, input logic [15:0] exp_tgt);
    alu(4'd5, 16'h5555, 3'd1, s, z, 1'b0, v);
    tick();
    check({tag, "_cmp_we"}, 32'(rf_we), 32'd0);
    check({tag, "_cmp_flags"}, 32'(flags), 32'({s, z, 1'b0, v}));
    br(cond, tgt);
    tick();
    check({tag, "_taken"}, 32'(br_taken), 32'(exp_taken));
    check({tag, "_target"}, 32'(br_target), 32'(exp_tgt));
    check({tag, "_br_we"}, 32'(rf_we), 32'd0);
    check({tag, "_br_flags"}, 32'(flags), 32'({s, z, 1'b0, v}));
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    rst_n = 1'b0;
    // Reset held two cycles while an instruction is offered.
    alu(4'd0, 16'hFFFF, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_outv", 32'(out_valid), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_br", 32'(br_taken), 32'd0);
    check("rst_odata", 32'(out_data), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // ADD with V and S set.
    alu(4'd0, 16'h8000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("add_we", 32'(rf_we), 32'd1);
    check("add_waddr", 32'(rf_waddr), 32'd3);
    check("add_wdata", 32'(rf_wdata), 32'h8000);
    check("add_flags", 32'(flags), 32'b1001);
    idle();
    tick();
    check("add_we_pulse", 32'(rf_we), 32'd0);

    // CMP then BE / BNE back to back.
    cmp_br("be", 1'b0, 1'b1, 1'b0, 3'd0, 16'h0040, 1'b1, 16'h0040);
    idle();
    tick();
    check("be_pulse", 32'(br_taken), 32'd0);
    check("be_hold_tgt", 32'(br_target), 32'h0040);
    cmp_br("bne", 1'b0, 1'b1, 1'b0, 3'd3, 16'h0080, 1'b0, 16'h0040);

    // OUT with a stalled consumer; a concurrent ADD must not be accepted.
    alu(4'd13, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'h1234);
    check("out_ready_lo", 32'(in_ready), 32'd0);
    check("out_no_we", 32'(rf_we), 32'd0);
    check("out_flags", 32'(flags), 32'b0100);
    alu(4'd0, 16'hBEEF, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ow_valid", 32'(out_valid), 32'd1);
      check("ow_data", 32'(out_data), 32'h1234);
      check("ow_ready", 32'(in_ready), 32'd0);
      check("ow_we", 32'(rf_we), 32'd0);
      check("ow_flags", 32'(flags), 32'b0100);
    end
    out_ready = 1'b1;
    tick();
    check("ow_exit_valid", 32'(out_valid), 32'd0);
    check("ow_exit_ready", 32'(in_ready), 32'd1);
    check("ow_exit_we", 32'(rf_we), 32'd0);
    check("ow_exit_data", 32'(out_data), 32'h1234);
    idle();
    tick();
    check("ordy_idle_valid", 32'(out_valid), 32'd0);
    check("ordy_idle_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Signed conditions and the unconditional / never cases.
    cmp_br("blt_t", 1'b1, 1'b0, 1'b0, 3'd1, 16'h0100, 1'b1, 16'h0100);
    cmp_br("blt_n", 1'b1, 1'b0, 1'b1, 3'd1, 16'h0180, 1'b0, 16'h0100);
    cmp_br("ble_t", 1'b0, 1'b1, 1'b0, 3'd2, 16'h0200, 1'b1, 16'h0200);
    cmp_br("ble_n", 1'b0, 1'b0, 1'b0, 3'd2, 16'h0280, 1'b0, 16'h0200);
    cmp_br("b_t", 1'b0, 1'b0, 1'b0, 3'd4, 16'h0300, 1'b1, 16'h0300);
    cmp_br("c7_n", 1'b0, 1'b1, 1'b0, 3'd7, 16'h0380, 1'b0, 16'h0300);

    // IN writes the register but leaves flags alone; opcode 7 is a no-op.
    alu(4'd12, 16'h00A5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("in_we", 32'(rf_we), 32'd1);
    check("in_waddr", 32'(rf_waddr), 32'd6);
    check("in_wdata", 32'(rf_wdata), 32'h00A5);
    check("in_flags", 32'(flags), 32'b0100);
    alu(4'd7, 16'h7777, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("nop_we", 32'(rf_we), 32'd0);
    check("nop_flags", 32'(flags), 32'b0100);
    check("nop_ready", 32'(in_ready), 32'd1);

    // HLT, then traffic that must be ignored.
    alu(4'd15, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_ready", 32'(in_ready), 32'd0);
    check("hlt_flags", 32'(flags), 32'b0100);
    alu(4'd0, 16'hDEAD, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hlt_we", 32'(rf_we), 32'd0);
      check("hlt_keep_flags", 32'(flags), 32'b0100);
      check("hlt_keep", 32'(halted), 32'd1);
      check("hlt_odata", 32'(out_data), 32'h1234);
    end
    idle();
    rst_n = 1'b0;
    tick();
    check("hlt_rst_halted", 32'(halted), 32'd0);
    check("hlt_rst_flags", 32'(flags), 32'd0);
    check("hlt_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Reset while an OUT is pending drops it.
    alu(4'd13, 16'hABCD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("out2_valid", 32'(out_valid), 32'd1);
    idle();
    rst_n = 1'b0;
    tick();
    check("out2_rst_valid", 32'(out_valid), 32'd0);
    check("out2_rst_data", 32'(out_data), 32'd0);
    check("out2_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
